// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: host-side bundle for the UART transmit controller.
// Carries the byte handshake (tx_data/tx_valid/tx_ready) and the
// configuration write port (cfg_div/cfg_we/cfg_two_stop/cfg_parity_odd).
// The register file drives it through the master modport. The controller
// receives it through the slave modport.
interface uart_tx_ctrl_if;
  logic [31:0] cfg_div;
  logic        cfg_we;
  logic        cfg_two_stop;
  logic        cfg_parity_odd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output cfg_div,
    output cfg_we,
    output cfg_two_stop,
    output cfg_parity_odd,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  cfg_div,
    input  cfg_we,
    input  cfg_two_stop,
    input  cfg_parity_odd,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller.
// Sequences the shared baud-rate generator (enable, synchronous reset and
// divisor) and serialises one byte per frame onto txd_o, LSB first.
// Bit boundaries are the rising edges of the generator's toggling tick.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the
// data bits. The parity bit is even or odd as selected by cfg_parity_odd.
module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int MIN_DIV   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_ctrl_if.slave host,
  output logic          baud_enable_o,
  output logic          baud_rst_o,
  output logic [31:0]   baud_counter_o,
  input  logic          baud_tick_i,
  output logic          txd_o,
  output logic          busy_o
);

  // Frame sequencer states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  // The generator's half-period is div>>1, so only even divisors are usable.
  localparam logic [31:0] MIN_DIV_W    = 32'(MIN_DIV);
  localparam logic [31:0] MIN_DIV_EVEN = MIN_DIV_W & ~32'd1;
  localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [7:0]  DATA_MASK    = 8'((1 << DATA_BITS) - 1);
`endif

  // Sequencer and serialiser registers
  logic [2:0]  state_q, state_d;
  logic        txd_q, txd_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        ready_q;
  logic        tick_q;

  // Shadow configuration (written any time) and active configuration
  // (frozen for the duration of a frame)
  logic [31:0] div_sh_q;
  logic        two_stop_sh_q;
  logic [31:0] div_q;
  logic        two_stop_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd_sh_q;
  logic        parity_bit_q;
`else
  logic        unused_parity_odd;
  assign unused_parity_odd = host.cfg_parity_odd;
`endif

  logic [31:0] cfg_div_eff;
  logic        accept;
  logic        tick_rise;

  assign accept    = host.tx_valid & ready_q;
  assign tick_rise = baud_tick_i & ~tick_q;

  // Clamp the requested divisor to MIN_DIV and round it down to even
  always_comb begin
    cfg_div_eff    = (host.cfg_div < MIN_DIV_W) ? MIN_DIV_W : host.cfg_div;
    cfg_div_eff[0] = 1'b0;
  end

  // Shadow configuration captured on every cfg_we, regardless of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_sh_q        <= MIN_DIV_EVEN;
      two_stop_sh_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_odd_sh_q <= 1'b0;
`endif
    end else if (host.cfg_we) begin
      div_sh_q        <= cfg_div_eff;
      two_stop_sh_q   <= host.cfg_two_stop;
`ifdef UART_TX_PARITY_EN
      parity_odd_sh_q <= host.cfg_parity_odd;
`endif
    end
  end

  // Active configuration (and the frame's parity bit) latched at byte acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= MIN_DIV_EVEN;
      two_stop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit_q <= 1'b0;
`endif
    end else if (accept) begin
      div_q        <= div_sh_q;
      two_stop_q   <= two_stop_sh_q;
`ifdef UART_TX_PARITY_EN
      parity_bit_q <= (^(host.tx_data & DATA_MASK)) ^ parity_odd_sh_q;
`endif
    end
  end

  // Registered copy of the tick for rising-edge detection, held low while the generator is reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else if ((state_q == S_IDLE) || (state_q == S_SYNC)) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= baud_tick_i;
    end
  end

  // Next-state and next-line logic; every tick rising edge ends one bit and starts the next
  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          state_d = S_SYNC;
          shift_d = host.tx_data;
        end
      end
      S_SYNC: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick_rise) begin
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick_rise) begin
          state_d   = S_DATA;
          txd_d     = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick_rise) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d    = S_PARITY;
            txd_d      = parity_bit_q;
`else
            state_d    = S_STOP;
            txd_d      = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_rise) begin
          state_d    = S_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (tick_rise) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Sequencer state, line and ready registers; ready stays low for one cycle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      txd_q      <= 1'b1;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ready_q    <= (state_d == S_IDLE);
    end
  end

  assign host.tx_ready  = ready_q;
  assign txd_o          = txd_q;
  assign busy_o         = (state_q != S_IDLE);
  assign baud_enable_o  = (state_q != S_IDLE);
  assign baud_rst_o     = (state_q == S_IDLE) || (state_q == S_SYNC);
  assign baud_counter_o = div_q;

endmodule
